// File: rtl/turret_pwm_apb.sv
// turret_pwm_apb: APB3 slave generating NUM_CH servo PWM outputs with clamped
// per-channel targets, frame-synchronous updates and limit-switch fault latching.
// Optional feature macro: TURRET_PWM_SLEW_EN (SLEW register, ramping, SNAP).
module turret_pwm_apb #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 21,
    parameter int PERIOD = 2000000,
    parameter int MIN_PW = 100000,
    parameter int MAX_PW = 200000
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NUM_CH-1:0] sw,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PW);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PW);
    localparam logic [CNT_W-1:0] MID_C  = CNT_W'((MIN_PW + MAX_PW) / 2);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PERIOD - 1);

    // Limit a requested pulse width to the mechanically safe window.
    function automatic logic [CNT_W-1:0] clamp_pw(input logic [31:0] v);
        logic [CNT_W-1:0] r;
        if (v < 32'(MIN_PW)) begin
            r = MIN_C;
        end else if (v > 32'(MAX_PW)) begin
            r = MAX_C;
        end else begin
            r = v[CNT_W-1:0];
        end
        return r;
    endfunction

`ifdef TURRET_PWM_SLEW_EN
    // Move cur toward tgt by at most slew; a zero slew means jump straight there.
    function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt,
                                                     input logic [CNT_W-1:0] slew);
        logic [CNT_W-1:0] r;
        if (slew == {CNT_W{1'b0}}) begin
            r = tgt;
        end else if (tgt > cur) begin
            if ((tgt - cur) > slew) r = cur + slew;
            else                    r = tgt;
        end else begin
            if ((cur - tgt) > slew) r = cur - slew;
            else                    r = tgt;
        end
        return r;
    endfunction

    logic [CNT_W-1:0] slew_q, slew_d;
    logic             snap_q, snap_d;
`endif

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         en_q, en_d;
    logic [NUM_CH-1:0][CNT_W-1:0] tgt_q, tgt_d, cur_q, cur_d;
    logic [NUM_CH-1:0]            fault_q, fault_d;
    logic [NUM_CH-1:0]            sw_meta_q, sw_sync_q;
    logic [NUM_CH-1:0]            pwm_q, pwm_d;

    logic        access_s, aligned_s, err_s, good_wr_s, boundary_s;
    logic [5:0]  word_s;
    logic [2:0]  tgt_idx_s, cur_idx_s;
    logic        ctrl_hit_s, stat_hit_s, slew_hit_s, tgt_ok_s, cur_ok_s;
    logic [7:0]  settled_s, fault8_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    // Only the low address byte is decoded.
    assign unused_s = ^PADDR[31:8];

    // Address decode, error detection and read-data mux for the access phase.
    always_comb begin
        access_s   = PSEL & PENABLE;
        word_s     = PADDR[7:2];
        aligned_s  = (PADDR[1:0] == 2'b00);
        tgt_idx_s  = 3'(word_s - 6'd4);
        cur_idx_s  = 3'(word_s - 6'd12);
        ctrl_hit_s = aligned_s && (word_s == 6'd0);
        stat_hit_s = aligned_s && (word_s == 6'd1);
        slew_hit_s = aligned_s && (word_s == 6'd2);
        tgt_ok_s   = aligned_s && (word_s >= 6'd4) && (word_s <= 6'd11) &&
                     (32'(tgt_idx_s) < 32'(NUM_CH));
        cur_ok_s   = aligned_s && (word_s >= 6'd12) && (word_s <= 6'd19) &&
                     (32'(cur_idx_s) < 32'(NUM_CH));

        settled_s = 8'h00;
        fault8_s  = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            settled_s[i] = (cur_q[i] == tgt_q[i]);
            fault8_s[i]  = fault_q[i];
        end

        if (!(ctrl_hit_s || stat_hit_s || slew_hit_s || tgt_ok_s || cur_ok_s)) begin
            err_s = access_s;
        end else if (PWRITE && cur_ok_s) begin
            err_s = access_s;
        end else if (PWRITE && stat_hit_s && (PWDATA[7:0] != 8'h00)) begin
            err_s = access_s;
        end else begin
            err_s = 1'b0;
        end
        good_wr_s = access_s & PWRITE & ~err_s;

        rdata_s = 32'h0000_0000;
        if (access_s && !PWRITE && !err_s) begin
            if (ctrl_hit_s) begin
                rdata_s = {31'h0000_0000, en_q};
            end else if (stat_hit_s) begin
                rdata_s = {16'h0000, fault8_s, settled_s};
            end else if (slew_hit_s) begin
`ifdef TURRET_PWM_SLEW_EN
                rdata_s = 32'(slew_q);
`else
                rdata_s = 32'h0000_0000;
`endif
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (tgt_ok_s && (tgt_idx_s == 3'(i))) rdata_s = 32'(tgt_q[i]);
                    else if (cur_ok_s && (cur_idx_s == 3'(i))) rdata_s = 32'(cur_q[i]);
                    else rdata_s = rdata_s;
                end
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Next-state logic: register writes, frame counter, per-channel update and PWM compare.
    always_comb begin
        boundary_s = (cnt_q == LAST_C);

        if (good_wr_s && ctrl_hit_s) en_d = PWDATA[0];
        else                         en_d = en_q;

        // Enabling restarts the frame so the first pulse is never truncated.
        if (en_d && !en_q)   cnt_d = {CNT_W{1'b0}};
        else if (boundary_s) cnt_d = {CNT_W{1'b0}};
        else                 cnt_d = cnt_q + CNT_W'(1);

`ifdef TURRET_PWM_SLEW_EN
        if (good_wr_s && slew_hit_s) slew_d = PWDATA[CNT_W-1:0];
        else                         slew_d = slew_q;
        // A SNAP written on a boundary cycle stays pending for the following boundary.
        snap_d = (good_wr_s & ctrl_hit_s & PWDATA[1]) | (snap_q & ~boundary_s);
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            if (good_wr_s && tgt_ok_s && (tgt_idx_s == 3'(i))) tgt_d[i] = clamp_pw(PWDATA);
            else                                                 tgt_d[i] = tgt_q[i];

            // Boundary sees the registered target, so a same-cycle write lands one frame later.
            if (boundary_s) begin
`ifdef TURRET_PWM_SLEW_EN
                if (snap_q) cur_d[i] = tgt_q[i];
                else        cur_d[i] = step_toward(cur_q[i], tgt_q[i], slew_q);
`else
                cur_d[i] = tgt_q[i];
`endif
            end else begin
                cur_d[i] = cur_q[i];
            end

            // Switch set beats a simultaneous write-1-to-clear.
            fault_d[i] = sw_sync_q[i] |
                         (fault_q[i] & ~(good_wr_s & stat_hit_s & PWDATA[8 + i]));

            // en_d gating makes a disable take effect one cycle after the write.
            pwm_d[i] = en_q & en_d & ~sw_sync_q[i] & ~fault_q[i] & (cnt_q < cur_q[i]);
        end
    end

    // Two-flop synchroniser for the asynchronous limit switches.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sw_meta_q <= {NUM_CH{1'b0}};
            sw_sync_q <= {NUM_CH{1'b0}};
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Architectural state and registered PWM outputs.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cnt_q   <= {CNT_W{1'b0}};
            en_q    <= 1'b0;
            tgt_q   <= {NUM_CH{MID_C}};
            cur_q   <= {NUM_CH{MID_C}};
            fault_q <= {NUM_CH{1'b0}};
            pwm_q   <= {NUM_CH{1'b0}};
`ifdef TURRET_PWM_SLEW_EN
            slew_q  <= {CNT_W{1'b0}};
            snap_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            fault_q <= fault_d;
            pwm_q   <= pwm_d;
`ifdef TURRET_PWM_SLEW_EN
            slew_q  <= slew_d;
            snap_q  <= snap_d;
`endif
        end
    end

    assign PRDATA  = rdata_s;
    assign PSLVERR = err_s;
    assign PREADY  = 1'b1;
    assign pwm_out = pwm_q;

endmodule

// File: doc/turret_pwm_apb.md
# turret_pwm_apb

Parametrised APB3 slave generating `NUM_CH` servo PWM outputs for the turret, successor to the fixed two-channel bus interface. Hangs off the MSS master APB via CoreAPB3 slot 0, on `FAB_CLK` and `M2F_RESET_N`. Per-channel target pulse widths are clamped to a safe window and applied glitch-free at frame boundaries, with an optional slew-rate limit. Per-channel limit-switch inputs force channels off and latch sticky faults.

## Interface
- `NUM_CH`, 2: channel count, 1..8.
- `CNT_W`, 21: frame counter / pulse width register width.
- `PERIOD`, 2000000: frame length in PCLK cycles (20 ms at 100 MHz); must be < 2^CNT_W.
- `MIN_PW`, 100000: minimum pulse width in cycles (1 ms).
- `MAX_PW`, 200000: maximum pulse width in cycles (2 ms); MIN_PW < MAX_PW < PERIOD.
- `PCLK` in 1: fabric clock; the block's only clock.
- `PRESERN` in 1: asynchronous active-low reset.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB3 control.
- `PADDR` in 32: byte address; only [7:0] decoded.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: constant 1.
- `PSLVERR` out 1: access error.
- `sw` in NUM_CH: limit switches, asynchronous, active-high.
- `pwm_out` out NUM_CH: servo PWM, registered.

## Operation
- Registers (word-aligned):
  - 0x00 CTRL: [0] EN (rw). [1] SNAP (write-1, reads 0).
  - 0x04 STATUS: [7:0] SETTLED (ro, cur==tgt). [15:8] FAULT (sticky, write-1-to-clear).
  - 0x08 SLEW: [CNT_W-1:0] max per-frame step (rw), 0 = unlimited.
  - 0x10+4i TARGET[i]: rw.
  - 0x30+4i CURRENT[i]: ro.
- Unimplemented or out-of-range channel address (i ≥ NUM_CH), or a write to a ro register: PSLVERR=1 in the access phase, no state change, PRDATA=0. Unused bits read 0.
- TARGET writes are clamped to [MIN_PW, MAX_PW]. The clamped value is stored and read back.
- Frame counter runs 0..PERIOD-1 and wraps. Frame boundary = the cycle in which cnt==PERIOD-1.
- At a frame boundary, per channel: if SNAP is pending, cur←tgt. Otherwise cur moves toward tgt by min(|tgt−cur|, SLEW), or cur←tgt if SLEW=0. SNAP pending clears at that boundary.
- `pwm_out[i]` is registered: `EN & ~sw_s[i] & ~FAULT[i] & (cnt < cur[i])`.
- `sw` passes through a 2-FF synchroniser to give `sw_s`. `sw_s[i]`=1 sets FAULT[i].
  - Set has priority over a simultaneous W1C.
  - The channel stays forced low until FAULT[i] is cleared and `sw_s[i]`=0.
  - Ramping continues while the channel is forced low.

## Timing
- Reset values: `pwm_out`=0, PRDATA=0, PSLVERR=0, cnt=0, EN=0, SLEW=0, FAULT=0, tgt=cur=(MIN_PW+MAX_PW)/2.
- APB is zero wait-state.
  - Writes commit on the PSEL&PENABLE&PWRITE cycle.
  - Read data is combinational during the access phase, 0 otherwise.
- A TARGET write in the same cycle as a frame boundary: the boundary uses the old tgt. The new value takes effect at the next boundary.
- EN 0→1 resets cnt to 0 on the next cycle, so the first pulse is complete. EN→0 drives all outputs low one cycle after the write.
- `pwm_out` rises one cycle after cnt=0 and stays high for exactly cur cycles. cur changes only at a boundary, so no runt or stretched pulses.
- Switch-to-output latency: ≤3 cycles (2 synchroniser stages + output register).
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous).

## Configuration
- `TURRET_PWM_SLEW_EN` defined: SLEW register and ramping as described.
- Not defined:
  - Offset 0x08 reads 0; writes are accepted and ignored (PSLVERR=0).
  - cur←tgt at every frame boundary.
  - SNAP has no additional effect.

## Test plan
- Reset, EN=1, no writes → both outputs high for 150000 cycles in every 2000000-cycle frame; SETTLED=0x03.
- Write TARGET0=50000 → reads back 100000. Write 0x3FFFFF → reads 200000. The pulse changes only at the next frame start.
- SLEW=20000, TARGET0=200000 from 150000 → successive pulses of 170000, 190000, 200000; SETTLED[0] set after the third frame. Without the macro: 200000 in the first frame.
- Assert sw[1] mid-pulse → pwm_out[1] low within 3 cycles and FAULT[1]=1. Release, write STATUS=0x0200 → output resumes at the next frame.
- Read 0x18 with NUM_CH=2, and write 0x04 bits [7:0] → PSLVERR=1, no state change, PRDATA=0.
- Pulse PRESERN low mid-pulse → `pwm_out`=0 immediately; registers return to reset values.
